mio_arbiter: RTL and testbench

Two-master arbiter for the shared memory/IO bus. It sits between the multi-cycle CPU's memory port (master 0) and a second bus master such as the display/sprite fetch engine (master 1), and drives the single memory/IO slave port. It serialises one transaction at a time, alternates priority round-robin, and aborts hung slave accesses with a timeout error.

---
 rtl/mio_arbiter.sv | 144 ++++++++++++++
 tb/tb_mio_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_arbiter.sv
// mio_arbiter: two-master round-robin arbiter driving one memory/IO slave port.
// One transaction at a time; slave accesses that never ack are aborted with an error.
module mio_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ack,
   output logic          s_req,
   output logic          s_we,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_ack,
   output logic [1:0]    grant,
   output logic          timeout_err,
   output logic [1:0]    o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   state_t        r_state;
   state_t        w_next;
   logic          w_start;
   logic          w_pick_m1;
   logic          w_timeout;
   logic          w_done;
   logic [7:0]    r_cnt;
   logic          r_last;
   logic [1:0]    r_grant;
   logic          r_s_req;
   logic          r_s_we;
   logic [AW-1:0] r_s_addr;
   logic [DW-1:0] r_s_wdata;
   logic [DW-1:0] r_rdata;
   logic          r_m0_ack;
   logic          r_m1_ack;
   logic          r_timeout_err;

   // r_last = 1 means master 1 was served most recently, so master 0 wins a tie.
   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_pick_m1 = 1'b0;
      w_timeout = (r_cnt == LP_CNT_LAST);
      w_done    = 1'b0;
      case (r_state)
         IDLE: begin
            w_start   = m0_req | m1_req;
            w_pick_m1 = m1_req & (~m0_req | ~r_last);
            if (w_start) w_next = ACCESS;
         end
         ACCESS: begin
            w_done = s_ack | w_timeout;
            if (w_done) w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_last        <= 1'b1;
         r_grant       <= 2'b00;
         r_s_req       <= 1'b0;
         r_s_we        <= 1'b0;
         r_s_addr      <= '0;
         r_s_wdata     <= '0;
         r_rdata       <= '0;
         r_m0_ack      <= 1'b0;
         r_m1_ack      <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_m0_ack      <= 1'b0;
         r_m1_ack      <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_grant   <= w_pick_m1 ? 2'b10 : 2'b01;
                  r_s_req   <= 1'b1;
                  r_s_we    <= w_pick_m1 ? m1_we    : m0_we;
                  r_s_addr  <= w_pick_m1 ? m1_addr  : m0_addr;
                  r_s_wdata <= w_pick_m1 ? m1_wdata : m0_wdata;
                  r_cnt     <= '0;
               end
            end
            ACCESS: begin
               // s_ack takes precedence over an expiring counter.
               if (w_done) begin
                  r_s_req       <= 1'b0;
                  r_m0_ack      <= r_grant[0];
                  r_m1_ack      <= r_grant[1];
                  r_timeout_err <= ~s_ack;
                  r_rdata       <= (s_ack && !r_s_we) ? s_rdata : '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            RESP: begin
               r_last  <= r_grant[1];
               r_grant <= 2'b00;
            end
            default: r_grant <= 2'b00;
         endcase
      end
   end

   assign m0_rdata    = r_rdata;
   assign m1_rdata    = r_rdata;
   assign m0_ack      = r_m0_ack;
   assign m1_ack      = r_m1_ack;
   assign s_req       = r_s_req;
   assign s_we        = r_s_we;
   assign s_addr      = r_s_addr;
   assign s_wdata     = r_s_wdata;
   assign grant       = r_grant;
   assign timeout_err = r_timeout_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: directed scenarios plus random two-master traffic
// checked against a transaction-level arbitration/latency model.
module tb_mio_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic clk;
  logic reset;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic m0_ack, m1_ack;
  logic s_req, s_we, s_ack;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [1:0] grant;
  logic timeout_err;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  mio_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_ack = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    m0_req = 1; m1_req = 1; m0_addr = 32'hDEAD_BEEF; m0_wdata = 32'h0BAD_F00D;
    s_ack = 1; s_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_s_req: got %b want 0", s_req); end
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_vec++; if ({m0_ack, m1_ack, timeout_err, s_we} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {m0_ack, m1_ack, timeout_err, s_we}); end
    n_vec++; if ({s_addr, s_wdata, m0_rdata} !== '0) begin n_err++; $display("FAIL reset_data: got %h %h %h want 0", s_addr, s_wdata, m0_rdata); end
    idle_inputs();
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0040;
    @(negedge clk);
    n_vec++; if (s_req !== 1'b1) begin n_err++; $display("FAIL single_s_req: got %b want 1", s_req); end
    n_vec++; if (s_addr !== 32'h40 || s_we !== 1'b0) begin n_err++; $display("FAIL single_s_addr: got %h we=%b want 00000040 we=0", s_addr, s_we); end
    n_vec++; if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b want 01", grant); end
    s_ack = 1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    n_vec++; if ({m0_ack, m1_ack} !== 2'b10) begin n_err++; $display("FAIL single_ack: got m0=%b m1=%b want m0=1 m1=0", m0_ack, m1_ack); end
    n_vec++; if (m0_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL single_rdata: got %h want 12345678", m0_rdata); end
    n_vec++; if (s_req !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL single_resp: got s_req=%b err=%b want 0 0", s_req, timeout_err); end
    m0_req = 0; s_ack = 0;
    @(negedge clk);
    n_vec++; if (grant !== 2'b00 || m0_ack !== 1'b0) begin n_err++; $display("FAIL single_idle: got grant=%b ack=%b want 00 0", grant, m0_ack); end
  endtask

  task automatic test_write_wait();
    m1_req = 1; m1_we = 1; m1_addr = 32'h1000_0000; m1_wdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_vec++; if ({s_req, s_we, s_addr, s_wdata} !== {2'b11, 32'h1000_0000, 32'hCAFE_F00D}) begin
        n_err++; $display("FAIL write_stable_%0d: got req=%b we=%b %h %h want 1 1 10000000 cafef00d", k, s_req, s_we, s_addr, s_wdata);
      end
      m1_addr = $urandom; m1_wdata = $urandom;
      s_ack = (k == 4); s_rdata = 32'h7777_7777;
    end
    @(negedge clk);
    n_vec++; if ({m0_ack, m1_ack, timeout_err} !== 3'b010) begin n_err++; $display("FAIL write_ack: got m0=%b m1=%b err=%b want 0 1 0", m0_ack, m1_ack, timeout_err); end
    n_vec++; if (m1_rdata !== '0) begin n_err++; $display("FAIL write_rdata: got %h want 0", m1_rdata); end
    m1_req = 0; s_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cnt;
    bit seen;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100; s_ack = 0; s_rdata = 32'hABCD_EF01;
    cnt = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (m0_ack) seen = 1;
      else if (s_req) cnt++;
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL timeout_no_ack: got none want ack within 40 cycles"); end
    n_vec++; if (cnt != TIMEOUT) begin n_err++; $display("FAIL timeout_len: got %0d want %0d", cnt, TIMEOUT); end
    n_vec++; if (timeout_err !== 1'b1 || m0_rdata !== '0) begin n_err++; $display("FAIL timeout_err: got err=%b rdata=%h want 1 0", timeout_err, m0_rdata); end
    m0_req = 0;
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h0000_0104;
    @(negedge clk);
    s_ack = 1; s_rdata = 32'h0F0F_0F0F;
    @(negedge clk);
    n_vec++; if ({m0_ack, timeout_err} !== 2'b10 || m0_rdata !== 32'h0F0F_0F0F) begin n_err++; $display("FAIL timeout_recover: got ack=%b err=%b rdata=%h want 1 0 0f0f0f0f", m0_ack, timeout_err, m0_rdata); end
    m0_req = 0; s_ack = 0;
    @(negedge clk);
    m0_req = 1; m0_addr = 32'h0000_0108;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      s_ack = (k == TIMEOUT); s_rdata = 32'h5A5A_0015;
    end
    @(negedge clk);
    n_vec++; if ({m0_ack, timeout_err} !== 2'b10 || m0_rdata !== 32'h5A5A_0015) begin n_err++; $display("FAIL timeout_last_cycle_ack: got ack=%b err=%b rdata=%h want 1 0 5a5a0015", m0_ack, timeout_err, m0_rdata); end
    m0_req = 0; s_ack = 0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n_srv;
    int last_c;
    int srv;
    do_reset();
    m0_req = 1; m1_req = 1; s_ack = 1; s_rdata = 32'h5555_0000;
    n_srv = 0; last_c = 0;
    for (int c = 1; c <= 20 && n_srv < 4; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        n_vec++; if ((m0_ack && m1_ack) || (m0_ack && grant !== 2'b01) || (m1_ack && grant !== 2'b10)) begin
          n_err++; $display("FAIL contention_ack_grant: got acks=%b%b grant=%b want ack matching grant", m1_ack, m0_ack, grant);
        end
        srv = m1_ack ? 1 : 0;
        n_vec++; if (srv != n_srv % 2) begin n_err++; $display("FAIL contention_order_%0d: got m%0d want m%0d", n_srv, srv, n_srv % 2); end
        if (n_srv > 0) begin
          n_vec++; if (c - last_c != 3) begin n_err++; $display("FAIL contention_period: got %0d want 3", c - last_c); end
        end
        last_c = c;
        n_srv++;
      end
    end
    n_vec++; if (n_srv != 4) begin n_err++; $display("FAIL contention_count: got %0d want 4", n_srv); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'hA5A5_0000; m0_wdata = 32'h1111_2222;
    repeat (2) @(negedge clk);
    n_vec++; if (s_req !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got s_req=%b want 1", s_req); end
    reset = 0; m1_req = 1;
    @(negedge clk);
    n_vec++; if ({s_req, s_we, grant, m0_ack, m1_ack, timeout_err} !== 7'b0) begin
      n_err++; $display("FAIL rstmid_flags: got %b want 0000000", {s_req, s_we, grant, m0_ack, m1_ack, timeout_err});
    end
    n_vec++; if ({s_addr, s_wdata} !== '0) begin n_err++; $display("FAIL rstmid_data: got %h %h want 0 0", s_addr, s_wdata); end
    reset = 1;
    @(negedge clk);
    n_vec++; if (grant !== 2'b01 || m0_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_regrant: got grant=%b ack=%b want 01 0", grant, m0_ack); end
    do_reset();
  endtask

  task automatic test_withdraw();
    int spurious;
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 32'h0000_2000;
    @(negedge clk);
    n_vec++; if (grant !== 2'b10) begin n_err++; $display("FAIL withdraw_grant: got %b want 10", grant); end
    m1_req = 0;
    @(negedge clk);
    s_ack = 1; s_rdata = 32'h2468_ACE0;
    @(negedge clk);
    n_vec++; if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== 32'h2468_ACE0) begin n_err++; $display("FAIL withdraw_ack: got m0=%b m1=%b rdata=%h want 0 1 2468ace0", m0_ack, m1_ack, m1_rdata); end
    s_ack = 0;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (grant !== 2'b00 || s_req || m0_ack || m1_ack) spurious++;
    end
    n_vec++; if (spurious != 0) begin n_err++; $display("FAIL withdraw_spurious: got %0d busy cycles want 0", spurious); end
  endtask

  // Random two-master traffic against a transaction-level model: a grant follows
  // the round-robin rule on the requests seen, s_req lasts min(wait+1, TIMEOUT)
  // cycles, then exactly one ack to the owner, then grant drops.
  task automatic test_random(input int n_cycles);
    logic act[2];
    logic r_we[2];
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wdata[2];
    int gap[2];
    logic prev_req[2];
    bit done[2];
    int last_srv, owner, win, cyc, d, exp_len, n_txn;
    bit exp_err;
    logic g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, ack_data, exp_data;
    do_reset();
    exp_q.delete();
    for (int m = 0; m < 2; m++) begin act[m] = 0; gap[m] = 0; prev_req[m] = 0; r_we[m] = 0; r_addr[m] = '0; r_wdata[m] = '0; end
    last_srv = 1; owner = -1; cyc = 0; d = 0; exp_len = 0; exp_err = 0; n_txn = 0;
    g_we = 0; g_addr = '0; g_wdata = '0; ack_data = '0;
    for (int t = 0; t < n_cycles; t++) begin
      @(negedge clk);
      done[0] = 0; done[1] = 0;
      if (owner < 0 && grant !== 2'b00) begin
        win = (prev_req[0] && prev_req[1]) ? (last_srv == 0 ? 1 : 0) : (prev_req[0] ? 0 : 1);
        n_vec++; if (!(prev_req[0] || prev_req[1]) || grant !== (win == 1 ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL rand_grant t=%0d: got %b want m%0d (req %b%b last m%0d)", t, grant, win, prev_req[1], prev_req[0], last_srv);
        end
        owner = win; cyc = 0;
        g_we = r_we[win]; g_addr = r_addr[win]; g_wdata = r_wdata[win];
        d = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3) : $urandom_range(0, 3);
        exp_err = (d + 1 > TIMEOUT);
        exp_len = exp_err ? TIMEOUT : d + 1;
        ack_data = $urandom;
        exp_q.push_back((exp_err || g_we) ? '0 : ack_data);
      end
      if (owner >= 0) begin
        cyc++;
        if (cyc <= exp_len) begin
          n_vec++; if ({s_req, s_we, s_addr, s_wdata} !== {1'b1, g_we, g_addr, g_wdata} || m0_ack || m1_ack) begin
            n_err++; $display("FAIL rand_access t=%0d: got req=%b we=%b %h %h ack=%b%b want 1 %b %h %h 00", t, s_req, s_we, s_addr, s_wdata, m1_ack, m0_ack, g_we, g_addr, g_wdata);
          end
          s_ack = (cyc == d + 1);
          s_rdata = s_ack ? ack_data : DW'($urandom);
        end else if (cyc == exp_len + 1) begin
          exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : ~'0;
          n_vec++; if ({s_req, m1_ack, m0_ack} !== {1'b0, owner == 1, owner == 0} || timeout_err !== exp_err || m0_rdata !== exp_data) begin
            n_err++; $display("FAIL rand_resp t=%0d: got req=%b ack=%b%b err=%b rdata=%h want 0 m%0d err=%b rdata=%h", t, s_req, m1_ack, m0_ack, timeout_err, m0_rdata, owner, exp_err, exp_data);
          end
          done[owner] = 1; last_srv = owner; n_txn++;
          s_ack = 1'($urandom); s_rdata = $urandom;
        end else begin
          n_vec++; if (grant !== 2'b00 || s_req || m0_ack || m1_ack) begin
            n_err++; $display("FAIL rand_release t=%0d: got grant=%b req=%b ack=%b%b want 00 0 00", t, grant, s_req, m1_ack, m0_ack);
          end
          owner = -1;
          s_ack = 1'($urandom); s_rdata = $urandom;
        end
      end else begin
        n_vec++; if (s_req || m0_ack || m1_ack) begin n_err++; $display("FAIL rand_idle t=%0d: got req=%b ack=%b%b want 0 00", t, s_req, m1_ack, m0_ack); end
        s_ack = 1'($urandom); s_rdata = $urandom;
      end
      // master drivers: hold req until own ack, optionally re-request at once
      for (int m = 0; m < 2; m++) begin
        if (done[m]) begin act[m] = 0; gap[m] = $urandom_range(0, 3); end
        if (!act[m]) begin
          if (gap[m] > 0) gap[m]--;
          else if ($urandom_range(0, 3) != 0) begin
            act[m] = 1; r_we[m] = 1'($urandom); r_addr[m] = $urandom; r_wdata[m] = $urandom;
          end
        end else if (owner == m && $urandom_range(0, 1) == 1) begin
          r_addr[m] = $urandom; r_wdata[m] = $urandom;
        end
      end
      m0_req = act[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0];
      m1_req = act[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1];
      prev_req[0] = act[0]; prev_req[1] = act[1];
    end
    n_vec++; if (n_txn < 50) begin n_err++; $display("FAIL rand_progress: got %0d transactions want >= 50", n_txn); end
    do_reset();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_wait();
    test_timeout();
    test_contention();
    test_reset_mid();
    test_withdraw();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
